main_memory_dp: RTL and testbench

- Parametrised dual-port word memory for the MIC-1 datapath. Port A is read/write (MAR/MDR side); port B is read-only (PC/MBR fetch side).
- Generalises the fixed 9-bit, single-cycle main memory with:
  - configurable width and depth;
  - configurable pipelined read latency;
  - valid strobes;
  - out-of-range error flags;
  - a post-reset zero-fill sequencer.

---
 rtl/main_memory_dp.sv | 146 ++++++++++++++
 tb/tb_main_memory_dp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_dp.sv
// Dual-port word memory for the MIC-1 datapath: port A read/write, port B read-only,
// with a fixed-latency read pipeline, out-of-range flags and a post-reset zero-fill.
module main_memory_dp #(
    parameter int DATA_W         = 9,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 10,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    output logic              a_err,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              b_err
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LP_LAST  = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_init_we;
    logic [IDX_W-1:0]   r_init_cnt;
    logic               r_init_done;
    logic               r_a_werr;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_a_acc;
    logic               w_b_acc;
    logic               w_a_wr;
    logic [IDX_W-1:0]   w_a_idx;
    logic [IDX_W-1:0]   w_b_idx;
    logic [1:0]         w_rd;
    logic [1:0]         w_inr;
    logic [DATA_W-1:0]  w_rd_data [2];

    // Full-width compare: addresses beyond DEPTH are flagged, never aliased.
    assign w_inr[0] = ({1'b0, a_addr} < LP_DEPTH);
    assign w_inr[1] = ({1'b0, b_addr} < LP_DEPTH);
    assign w_a_idx  = a_addr[IDX_W-1:0];
    assign w_b_idx  = b_addr[IDX_W-1:0];

    assign w_a_acc  = a_req & r_init_done;
    assign w_b_acc  = b_req & r_init_done;
    assign w_a_wr   = w_a_acc & a_we & w_inr[0];
    assign w_rd[0]  = w_a_acc & ~a_we;
    assign w_rd[1]  = w_b_acc;

    assign w_rd_data[0] = w_inr[0] ? r_mem[w_a_idx] : '0;
    assign w_rd_data[1] = w_inr[1] ? r_mem[w_b_idx] : '0;

    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_init_cnt == LP_LAST) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_a_werr    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_init_done <= (w_state_next == ST_READY);
            r_a_werr    <= w_a_acc & a_we & ~w_inr[0];
            if (w_init_we) begin
                r_init_cnt <= r_init_cnt + IDX_W'(1);
            end
        end
    end

    // Array has no reset so it maps onto block RAM; nonblocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_a_wr) begin
            r_mem[w_a_idx] <= a_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              r_vld [RD_LATENCY];
            logic              r_err [RD_LATENCY];
            logic [DATA_W-1:0] r_dat [RD_LATENCY];

            // Data stages only advance behind a valid, so the last stage holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        r_vld[i] <= 1'b0;
                        r_err[i] <= 1'b0;
                        r_dat[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= w_rd[gi];
                    r_err[0] <= w_rd[gi] & ~w_inr[gi];
                    if (w_rd[gi]) begin
                        r_dat[0] <= w_rd_data[gi];
                    end
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_err[i] <= r_err[i-1];
                        if (r_vld[i-1]) begin
                            r_dat[i] <= r_dat[i-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign init_done = r_init_done;
    assign a_rdata   = g_port[0].r_dat[RD_LATENCY-1];
    assign a_rvalid  = g_port[0].r_vld[RD_LATENCY-1];
    assign a_err     = g_port[0].r_err[RD_LATENCY-1] | r_a_werr;
    assign b_rdata   = g_port[1].r_dat[RD_LATENCY-1];
    assign b_rvalid  = g_port[1].r_vld[RD_LATENCY-1];
    assign b_err     = g_port[1].r_err[RD_LATENCY-1];

endmodule

// File: tb/tb_main_memory_dp.sv
// Bench for main_memory_dp: three instances (read latency 1, 3, 4) share one stimulus
// stream and are compared every cycle against an edge-indexed reference model.
module tb_main_memory_dp;

    localparam int DW    = 9;
    localparam int AW    = 9;
    localparam int DEPTH = 10;
    localparam int ND    = 3;
    localparam int MAXC  = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata;

    logic          init_done [ND];
    logic          a_rvalid  [ND];
    logic          a_err     [ND];
    logic          b_rvalid  [ND];
    logic          b_err     [ND];
    logic [DW-1:0] a_rdata   [ND];
    logic [DW-1:0] b_rdata   [ND];

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            main_memory_dp #(
                .DATA_W        (DW),
                .ADDR_W        (AW),
                .DEPTH         (DEPTH),
                .RD_LATENCY    ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
                .CLEAR_ON_RESET(1)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .init_done(init_done[gi]),
                .a_req    (a_req),
                .a_we     (a_we),
                .a_addr   (a_addr),
                .a_wdata  (a_wdata),
                .a_rdata  (a_rdata[gi]),
                .a_rvalid (a_rvalid[gi]),
                .a_err    (a_err[gi]),
                .b_req    (b_req),
                .b_addr   (b_addr),
                .b_rdata  (b_rdata[gi]),
                .b_rvalid (b_rvalid[gi]),
                .b_err    (b_err[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // Reference model: word contents plus, for each accepting edge, what each port asked for.
    logic [DW-1:0] mem_m [DEPTH];
    bit            rd_v  [2][MAXC];
    bit            rd_e  [2][MAXC];
    logic [DW-1:0] rd_d  [2][MAXC];
    bit            wr_e  [MAXC];
    logic [DW-1:0] last_d [ND][2];
    int            cyc     = 0;
    int            rel_cyc = 1 << 20;
    int            rst_cyc = -1;
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic bit model_ready();
        return (cyc - rel_cyc) >= DEPTH;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, 511));
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        int  e0;
        bit  v;
        bit  er;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("init_done[%0d]", d), 32'(init_done[d]), 32'(model_ready()));
            for (int p = 0; p < 2; p++) begin
                e0 = cyc - lat_of(d) + 1;
                v  = (e0 > rst_cyc && e0 >= 0) ? rd_v[p][e0] : 1'b0;
                er = v ? rd_e[p][e0] : 1'b0;
                if (v) last_d[d][p] = rd_d[p][e0];
                if (p == 0) begin
                    er = er | wr_e[cyc];
                    check_eq($sformatf("a_rvalid[%0d]", d), 32'(a_rvalid[d]), 32'(v));
                    check_eq($sformatf("a_rdata[%0d]", d),  32'(a_rdata[d]),  32'(last_d[d][p]));
                    check_eq($sformatf("a_err[%0d]", d),    32'(a_err[d]),    32'(er));
                end else begin
                    check_eq($sformatf("b_rvalid[%0d]", d), 32'(b_rvalid[d]), 32'(v));
                    check_eq($sformatf("b_rdata[%0d]", d),  32'(b_rdata[d]),  32'(last_d[d][p]));
                    check_eq($sformatf("b_err[%0d]", d),    32'(b_err[d]),    32'(er));
                end
            end
        end
    endtask

    task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit br, input logic [AW-1:0] ba);
        int e;
        bit rdy;
        e   = cyc + 1;
        rdy = model_ready();
        if (e >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", e, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_addr = ba;
        if (rdy && br) begin
            rd_v[1][e] = 1'b1;
            rd_e[1][e] = (int'(ba) >= DEPTH);
            rd_d[1][e] = (int'(ba) < DEPTH) ? mem_m[int'(ba)] : '0;
            $display("cyc=%0d B rd addr=%0d exp=%0h", e, ba, rd_d[1][e]);
        end
        if (rdy && ar && !aw) begin
            rd_v[0][e] = 1'b1;
            rd_e[0][e] = (int'(aa) >= DEPTH);
            rd_d[0][e] = (int'(aa) < DEPTH) ? mem_m[int'(aa)] : '0;
            $display("cyc=%0d A rd addr=%0d exp=%0h", e, aa, rd_d[0][e]);
        end
        if (rdy && ar && aw) begin
            if (int'(aa) < DEPTH) mem_m[int'(aa)] = ad;
            else                  wr_e[e] = 1'b1;
            $display("cyc=%0d A wr addr=%0d data=%0h", e, aa, ad);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
    endtask

    task automatic model_reset();
        rel_cyc = cyc;
        rst_cyc = cyc;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int d = 0; d < ND; d++) begin
            last_d[d][0] = '0;
            last_d[d][1] = '0;
        end
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
                 DW'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), rand_addr());
        end
    endtask

    logic [DW-1:0] pat [5];

    initial begin
        pat[0] = 9'h0AA; pat[1] = 9'h0BB; pat[2] = 9'h0CC; pat[3] = 9'h0DD; pat[4] = 9'h0EE;
        for (int d = 0; d < ND; d++) begin
            last_d[d][0] = '0;
            last_d[d][1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; b_req = 1'b0; b_addr = '0;

        idle(3);
        rst_n = 1'b1;
        model_reset();

        // Requests during INIT must be ignored.
        for (int i = 0; i < DEPTH; i++) step(1, 1'(i % 2), AW'(i), 9'h1FF, 1, AW'(i));

        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), '0, 1, AW'(i));
        idle(4);

        for (int i = 0; i < 5; i++) step(1, 1, AW'(5 + i), pat[i], 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 1, AW'(5 + i));
        idle(4);

        step(1, 0, AW'(7), '0, 0, '0);
        idle(4);

        step(1, 1, AW'(6), 9'h155, 1, AW'(6));
        step(0, 0, '0, '0, 1, AW'(6));
        idle(4);

        step(1, 1, AW'(12), 9'h1AB, 1, AW'(511));
        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), '0, 1, AW'(DEPTH - 1 - i));
        idle(4);

        rand_traffic(300);

        // Reads in flight, then a short asynchronous reset between edges.
        for (int i = 0; i < 3; i++) step(1, 0, AW'(5 + i), '0, 1, AW'(7 - i));
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("rst_init_done[%0d]", d), 32'(init_done[d]), 32'(0));
            check_eq($sformatf("rst_a_rvalid[%0d]", d),  32'(a_rvalid[d]),  32'(0));
            check_eq($sformatf("rst_b_rvalid[%0d]", d),  32'(b_rvalid[d]),  32'(0));
            check_eq($sformatf("rst_a_rdata[%0d]", d),   32'(a_rdata[d]),   32'(0));
            check_eq($sformatf("rst_b_rdata[%0d]", d),   32'(b_rdata[d]),   32'(0));
            check_eq($sformatf("rst_a_err[%0d]", d),     32'(a_err[d]),     32'(0));
            check_eq($sformatf("rst_b_err[%0d]", d),     32'(b_err[d]),     32'(0));
        end
        rst_n = 1'b1;
        model_reset();

        rand_traffic(DEPTH);
        rand_traffic(100);
        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), '0, 1, AW'(i));
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
